layer_motion_sched: RTL and testbench
=====================================

// Module: layer_motion_sched
// PURPOSE
//  Per-frame motion scheduler for one multi-replica sprite layer.
//  - Holds position, velocity and flip state for each of REPLICAS instances.
//  - Accepts host commands at any time into shadow registers.
//  - On each frame_start (vblank) it walks the replicas, one per cycle, and commits
//    new hoffset/voffset/hflip/vflip.
//  - Outputs drive the layer's per-replica offset/flip inputs, so they never change mid-scan.
// PARAMETERS
//  HWIDTH    12   horizontal offset width
//  VWIDTH    12   vertical offset width
//  HWRAP     640  horizontal wrap span; positions kept in [0, HWRAP)
//  VWRAP     480  vertical wrap span; positions kept in [0, VWRAP)
//  SWIDTH    5    signed per-frame velocity width; |vel| < HWRAP and < VWRAP required
//  REPLICAS  4    number of sprite instances (>=1)
// PORTS
//  clk          in   1                 pixel clock
//  rst_n        in   1                 asynchronous active-low reset
//  frame_start  in   1                 one-cycle pulse at start of vblank
//  cmd_valid    in   1                 command present
//  cmd_ready    out  1                 command accepted when valid&&ready
//  cmd_op       in   2                 cmd_op_e: SET_POS, SET_VEL, SET_FLIP, NOP
//  cmd_idx      in   $clog2(REPLICAS)  target replica; idx>=REPLICAS is dropped
//  cmd_h        in   HWIDTH            SET_POS: x; SET_VEL: vx in low SWIDTH bits; SET_FLIP: bit0=hflip
//  cmd_v        in   VWIDTH            SET_POS: y; SET_VEL: vy in low SWIDTH bits; SET_FLIP: bit0=vflip
//  hoffset      out  HWIDTH [REPLICAS] committed x per replica
//  voffset      out  VWIDTH [REPLICAS] committed y per replica
//  hflip        out  1 [REPLICAS]      committed horizontal flip
//  vflip        out  1 [REPLICAS]      committed vertical flip
//  update_done  out  1                 one-cycle pulse after last replica committed
//  overrun      out  1                 sticky: frame_start arrived while UPDATE busy
// BEHAVIOUR
//  Reset:
//  - All outputs 0, cmd_ready=1, state IDLE.
//  - Shadow pos/vel/flip 0; pos_pend[] 0.
//  FSM:
//  - IDLE -> UPDATE on frame_start; idx counter <= 0.
//  - UPDATE processes replica idx each cycle; at idx==REPLICAS-1 -> DONE.
//  - DONE: update_done=1 for one cycle -> IDLE.
//  - Latency frame_start -> update_done = REPLICAS+1 cycles.
//  Handshake:
//  - cmd_ready=1 only in IDLE; commands are never lost or buffered elsewhere.
//  - SET_POS: shadow pos <= (cmd_h, cmd_v); pos_pend[idx] <= 1.
//  - SET_VEL: vel <= signed low SWIDTH bits.
//  - SET_FLIP: shadow flips written.
//  - NOP or out-of-range idx: accepted, no effect.
//  - Positions written by SET_POS are NOT range-checked.
//  Commit of replica i in UPDATE:
//  - If pos_pend[i]: output pos <= shadow pos and pos_pend[i] <= 0.
//  - Else: pos <= wrap(pos + vel).
//  - Flips are always copied from shadow.
//  wrap() rules:
//  - Compute at HWIDTH+1 signed.
//  - If sum < 0, add WRAP; else if sum >= WRAP, subtract WRAP.
//  - Exactly one correction suffices given the |vel| bound.
//  Simultaneous events and boundaries:
//  - frame_start with an accepted cmd in the same cycle: the cmd lands first and is
//    visible to this update.
//  - frame_start during UPDATE/DONE: ignored for motion; overrun <= 1.
//  - Reset mid-UPDATE: all state returns to reset values immediately; partial commits discarded.
// STRUCTURE
//  - layer_pkg: cmd_op_e (2-bit enum), sched_state_e {IDLE, UPDATE, DONE}.
//  - Sub-module wrap_step #(WIDTH, WRAP, SWIDTH): combinational pos+vel modulo wrap.
//    Instantiated twice (h, v) and shared across replicas via the idx mux.
// TESTING
//  1. Reset, then frame_start with vel=0.
//     -> all offsets 0; update_done exactly REPLICAS+1 cycles later.
//  2. SET_VEL idx1 vx=+3, vy=-2; SET_POS idx1 (10,5); 3 frames.
//     -> (10,5), (13,3), (16,1).
//  3. Wrap: pos x=638, vx=+5 -> 3; pos y=1, vy=-4 -> 477.
//  4. Same-cycle cmd SET_POS idx0 (100,200) + frame_start -> committed (100,200) this frame.
//  5. frame_start during UPDATE, plus cmd_valid held in UPDATE.
//     -> overrun=1, cmd_ready=0 until IDLE, cmd applied after.
//  6. rst_n low mid-UPDATE -> outputs 0 asynchronously; next frame behaves as test 1.

Source files
------------

// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types for the layer motion scheduler
package layer_pkg;

    typedef enum logic [1:0] {
        SET_POS  = 2'd0,
        SET_VEL  = 2'd1,
        SET_FLIP = 2'd2,
        NOP      = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/layer_motion_sched_if.sv
// rtl/layer_motion_sched_if.sv - host command channel of the layer motion scheduler
interface layer_motion_sched_if #(
    parameter int HWIDTH   = 12,
    parameter int VWIDTH   = 12,
    parameter int REPLICAS = 4
);
    localparam int IDXW = (REPLICAS > 1) ? $clog2(REPLICAS) : 1;

    logic                cmd_valid;
    logic                cmd_ready;
    layer_pkg::cmd_op_e  cmd_op;
    logic [IDXW-1:0]     cmd_idx;
    logic [HWIDTH-1:0]   cmd_h;
    logic [VWIDTH-1:0]   cmd_v;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_h, cmd_v,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_h, cmd_v,
        output cmd_ready
    );
endinterface

// File: rtl/wrap_step.sv
// rtl/wrap_step.sv - combinational pos+vel folded back into [0, WRAP) with one correction
module wrap_step #(
    parameter int WIDTH  = 12,
    parameter int WRAP   = 640,
    parameter int SWIDTH = 5
) (
    input  logic [WIDTH-1:0]  pos,
    input  logic [SWIDTH-1:0] vel,
    output logic [WIDTH-1:0]  next
);
    localparam logic signed [WIDTH:0] WRAP_S = (WIDTH+1)'(WRAP);

    logic signed [WIDTH:0] vel_ext;
    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] res;

    assign vel_ext = {{(WIDTH+1-SWIDTH){vel[SWIDTH-1]}}, vel};
    assign sum     = $signed({1'b0, pos}) + vel_ext;

    always_comb begin
        res = sum;
        if (sum < 0) begin
            res = sum + WRAP_S;
        end else if (sum >= WRAP_S) begin
            res = sum - WRAP_S;
        end
    end

    assign next = res[WIDTH-1:0];
endmodule

// File: rtl/layer_motion_sched.sv
// rtl/layer_motion_sched.sv - per-frame motion scheduler committing replica offsets/flips at vblank
module layer_motion_sched
    import layer_pkg::*;
#(
    parameter int HWIDTH   = 12,
    parameter int VWIDTH   = 12,
    parameter int HWRAP    = 640,
    parameter int VWRAP    = 480,
    parameter int SWIDTH   = 5,
    parameter int REPLICAS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    layer_motion_sched_if.slave      cmd,
    output logic [HWIDTH-1:0]        hoffset [REPLICAS],
    output logic [VWIDTH-1:0]        voffset [REPLICAS],
    output logic [REPLICAS-1:0]      hflip,
    output logic [REPLICAS-1:0]      vflip,
    output logic                     update_done,
    output logic                     overrun
);
    localparam int IDXW = (REPLICAS > 1) ? $clog2(REPLICAS) : 1;

    sched_state_e state, state_next;
    logic [IDXW-1:0]   idx;
    logic              last;
    logic              accept;
    logic              in_range;

    logic [HWIDTH-1:0] sh_h   [REPLICAS];
    logic [VWIDTH-1:0] sh_v   [REPLICAS];
    logic [SWIDTH-1:0] vel_h  [REPLICAS];
    logic [SWIDTH-1:0] vel_v  [REPLICAS];
    logic [REPLICAS-1:0] sh_hflip;
    logic [REPLICAS-1:0] sh_vflip;
    logic [REPLICAS-1:0] pos_pend;

    logic [HWIDTH-1:0] h_next;
    logic [VWIDTH-1:0] v_next;

    assign last          = (int'(idx) == REPLICAS - 1);
    assign cmd.cmd_ready = (state == IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign in_range      = (int'(cmd.cmd_idx) < REPLICAS);

    // One wrap unit per axis, shared by all replicas through the idx mux.
    wrap_step #(.WIDTH(HWIDTH), .WRAP(HWRAP), .SWIDTH(SWIDTH)) u_wrap_h (
        .pos (hoffset[idx]),
        .vel (vel_h[idx]),
        .next(h_next)
    );

    wrap_step #(.WIDTH(VWIDTH), .WRAP(VWRAP), .SWIDTH(SWIDTH)) u_wrap_v (
        .pos (voffset[idx]),
        .vel (vel_v[idx]),
        .next(v_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        update_done = 1'b0;
        unique case (state)
            IDLE:    if (frame_start) state_next = UPDATE;
            UPDATE:  if (last) state_next = DONE;
            DONE: begin
                update_done = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            overrun  <= 1'b0;
            pos_pend <= '0;
            sh_hflip <= '0;
            sh_vflip <= '0;
            hflip    <= '0;
            vflip    <= '0;
            for (int i = 0; i < REPLICAS; i++) begin
                sh_h[i]    <= '0;
                sh_v[i]    <= '0;
                vel_h[i]   <= '0;
                vel_v[i]   <= '0;
                hoffset[i] <= '0;
                voffset[i] <= '0;
            end
        end else begin
            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end

            if (state == UPDATE) begin
                idx <= idx + 1'b1;
            end else begin
                idx <= '0;
            end

            // Commands are only accepted in IDLE, so they never race a commit.
            if (accept && in_range) begin
                unique case (cmd.cmd_op)
                    SET_POS: begin
                        sh_h[cmd.cmd_idx]     <= cmd.cmd_h;
                        sh_v[cmd.cmd_idx]     <= cmd.cmd_v;
                        pos_pend[cmd.cmd_idx] <= 1'b1;
                    end
                    SET_VEL: begin
                        vel_h[cmd.cmd_idx] <= cmd.cmd_h[SWIDTH-1:0];
                        vel_v[cmd.cmd_idx] <= cmd.cmd_v[SWIDTH-1:0];
                    end
                    SET_FLIP: begin
                        sh_hflip[cmd.cmd_idx] <= cmd.cmd_h[0];
                        sh_vflip[cmd.cmd_idx] <= cmd.cmd_v[0];
                    end
                    NOP: ;
                    default: ;
                endcase
            end

            if (state == UPDATE) begin
                hflip[idx] <= sh_hflip[idx];
                vflip[idx] <= sh_vflip[idx];
                if (pos_pend[idx]) begin
                    hoffset[idx]  <= sh_h[idx];
                    voffset[idx]  <= sh_v[idx];
                    pos_pend[idx] <= 1'b0;
                end else begin
                    hoffset[idx] <= h_next;
                    voffset[idx] <= v_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer_motion_sched.sv
// tb/tb_layer_motion_sched.sv - randomized self-checking bench for layer_motion_sched
module tb_layer_motion_sched;
    import layer_pkg::*;

    localparam int HWIDTH   = 12;
    localparam int VWIDTH   = 12;
    localparam int HWRAP    = 640;
    localparam int VWRAP    = 480;
    localparam int SWIDTH   = 5;
    localparam int REPLICAS = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start;
    logic [HWIDTH-1:0]   hoffset [REPLICAS];
    logic [VWIDTH-1:0]   voffset [REPLICAS];
    logic [REPLICAS-1:0] hflip;
    logic [REPLICAS-1:0] vflip;
    logic update_done;
    logic overrun;

    layer_motion_sched_if #(.HWIDTH(HWIDTH), .VWIDTH(VWIDTH), .REPLICAS(REPLICAS)) bus ();

    layer_motion_sched #(
        .HWIDTH(HWIDTH), .VWIDTH(VWIDTH), .HWRAP(HWRAP), .VWRAP(VWRAP),
        .SWIDTH(SWIDTH), .REPLICAS(REPLICAS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .cmd        (bus),
        .hoffset    (hoffset),
        .voffset    (voffset),
        .hflip      (hflip),
        .vflip      (vflip),
        .update_done(update_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: integer positions, signed velocities, pending flags.
    int m_h [REPLICAS], m_v [REPLICAS];
    int m_vh [REPLICAS], m_vv [REPLICAS];
    int m_sh [REPLICAS], m_sv [REPLICAS];
    bit m_pend [REPLICAS];
    bit m_shf [REPLICAS], m_svf [REPLICAS];
    bit m_hf [REPLICAS], m_vf [REPLICAS];
    bit m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sext(input int raw);
        int v;
        v = raw % (1 << SWIDTH);
        if (v >= (1 << (SWIDTH - 1))) v -= (1 << SWIDTH);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < REPLICAS; i++) begin
            m_h[i] = 0; m_v[i] = 0; m_vh[i] = 0; m_vv[i] = 0;
            m_sh[i] = 0; m_sv[i] = 0; m_pend[i] = 0;
            m_shf[i] = 0; m_svf[i] = 0; m_hf[i] = 0; m_vf[i] = 0;
        end
        m_ovr = 0;
    endfunction

    function automatic void model_apply(input cmd_op_e op, input int idx, input int h, input int v);
        if (idx >= REPLICAS) return;
        case (op)
            SET_POS:  begin m_sh[idx] = h; m_sv[idx] = v; m_pend[idx] = 1; end
            SET_VEL:  begin m_vh[idx] = sext(h); m_vv[idx] = sext(v); end
            SET_FLIP: begin m_shf[idx] = h[0]; m_svf[idx] = v[0]; end
            default:  ;
        endcase
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < REPLICAS; i++) begin
            if (m_pend[i]) begin
                m_h[i] = m_sh[i];
                m_v[i] = m_sv[i];
                m_pend[i] = 0;
            end else begin
                m_h[i] = ((m_h[i] + m_vh[i]) % HWRAP + HWRAP) % HWRAP;
                m_v[i] = ((m_v[i] + m_vv[i]) % VWRAP + VWRAP) % VWRAP;
            end
            m_hf[i] = m_shf[i];
            m_vf[i] = m_svf[i];
        end
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < REPLICAS; i++) begin
            check($sformatf("%s_hoff%0d", tag, i), 32'(hoffset[i]), m_h[i]);
            check($sformatf("%s_voff%0d", tag, i), 32'(voffset[i]), m_v[i]);
            check($sformatf("%s_hflip%0d", tag, i), 32'(hflip[i]), 32'(m_hf[i]));
            check($sformatf("%s_vflip%0d", tag, i), 32'(vflip[i]), 32'(m_vf[i]));
        end
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic drive_cmd(input cmd_op_e op, input int idx, input int h, input int v);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_idx   = idx[1:0];
        bus.cmd_h     = h[HWIDTH-1:0];
        bus.cmd_v     = v[VWIDTH-1:0];
    endtask

    task automatic send_cmd(input cmd_op_e op, input int idx, input int h, input int v);
        int n;
        n = 0;
        @(negedge clk);
        drive_cmd(op, idx, h, v);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_accept_timeout", 32'(n), 0);
        model_apply(op, idx, h, v);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Called #1 after the edge that sampled frame_start; n0 negedges already seen.
    task automatic wait_done(input int n0, input string tag);
        int n;
        n = n0;
        while (!update_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), REPLICAS + 1);
    endtask

    task automatic finish_frame(input string tag);
        model_frame();
        check_outputs(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(update_done), 0);
        check({tag, "_ready_idle"}, 32'(bus.cmd_ready), 1);
    endtask

    task automatic run_frame(input string tag);
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        wait_done(0, tag);
        finish_frame(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = NOP;
        bus.cmd_idx = '0;
        bus.cmd_h = '0;
        bus.cmd_v = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_done", 32'(update_done), 0);
        check_outputs("rst");
        rst_n = 1'b1;

        // Zero velocity frame.
        run_frame("t1");

        // Velocity then position on replica 1, three frames.
        send_cmd(SET_VEL, 1, 3, 30);
        send_cmd(SET_POS, 1, 10, 5);
        run_frame("t2a");
        check("t2a_x", 32'(hoffset[1]), 10);
        check("t2a_y", 32'(voffset[1]), 5);
        run_frame("t2b");
        check("t2b_x", 32'(hoffset[1]), 13);
        check("t2b_y", 32'(voffset[1]), 3);
        run_frame("t2c");
        check("t2c_x", 32'(hoffset[1]), 16);
        check("t2c_y", 32'(voffset[1]), 1);

        // Wrap in both directions on replica 3.
        send_cmd(SET_POS, 3, 638, 1);
        send_cmd(SET_VEL, 3, 5, 28);
        send_cmd(SET_FLIP, 3, 1, 0);
        run_frame("t3a");
        run_frame("t3b");
        check("t3_x", 32'(hoffset[3]), 3);
        check("t3_y", 32'(voffset[3]), 477);
        check("t3_hflip", 32'(hflip[3]), 1);

        // Command and frame_start in the same cycle.
        @(negedge clk);
        drive_cmd(SET_POS, 0, 100, 200);
        frame_start = 1'b1;
        model_apply(SET_POS, 0, 100, 200);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        bus.cmd_valid = 1'b0;
        wait_done(0, "t4");
        finish_frame("t4");
        check("t4_x", 32'(hoffset[0]), 100);
        check("t4_y", 32'(voffset[0]), 200);

        // frame_start during UPDATE and a command held through the busy window.
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        @(negedge clk);
        check("t5_ready_busy", 32'(bus.cmd_ready), 0);
        frame_start = 1'b1;
        drive_cmd(SET_POS, 2, 50, 60);
        @(posedge clk);
        #1 frame_start = 1'b0;
        m_ovr = 1;
        wait_done(1, "t5");
        model_frame();
        check_outputs("t5");
        check("t5_ready_done", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        check("t5_ready_after", 32'(bus.cmd_ready), 1);
        model_apply(SET_POS, 2, 50, 60);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        run_frame("t5b");
        check("t5_x", 32'(hoffset[2]), 50);
        check("t5_y", 32'(voffset[2]), 60);

        // Reset in the middle of an update.
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6_rst");
        check("t6_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("t6");

        // Randomized command/frame mix.
        for (int it = 0; it < 30; it++) begin
            int ncmd;
            ncmd = $urandom_range(1, 4);
            for (int c = 0; c < ncmd; c++) begin
                int op;
                op = $urandom_range(0, 3);
                case (op)
                    0: send_cmd(SET_POS, $urandom_range(0, REPLICAS - 1),
                                $urandom_range(0, HWRAP - 1), $urandom_range(0, VWRAP - 1));
                    1: send_cmd(SET_VEL, $urandom_range(0, REPLICAS - 1),
                                $urandom_range(0, 4095), $urandom_range(0, 4095));
                    2: send_cmd(SET_FLIP, $urandom_range(0, REPLICAS - 1),
                                $urandom_range(0, 3), $urandom_range(0, 3));
                    default: send_cmd(NOP, $urandom_range(0, REPLICAS - 1),
                                      $urandom_range(0, 4095), $urandom_range(0, 4095));
                endcase
            end
            run_frame($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
